// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: pin synchroniser, clock deglitch filter,
// 11-bit frame deserialiser and 3/4-byte packet decoder.
module ps2_mouse_rx #(
    parameter int PKT_BYTES   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int BIT_TIMEOUT = 10000,
    parameter int PKT_TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       pkt_valid,
    output logic [2:0] btn,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic       x_ovf,
    output logic       y_ovf,
    output logic [3:0] dz,
    output logic       parity_err,
    output logic       frame_err,
    output logic       sync_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int BW = $clog2(BIT_TIMEOUT + 1);
    localparam int PW = $clog2(PKT_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   s_clk;
    logic                   s_dat;

    logic          fclk_q, fclk_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall_q;
    logic          fdat_q;

    state_t        state_q, state_d;
    logic [7:0]    sh_q, sh_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic          par_q, par_d;
    logic [BW-1:0] btmr_q, btmr_d;
    logic          bv_d, pe_d, fe_d;
    logic [7:0]    bd_d;

    logic          byte_valid_q;
    logic [7:0]    byte_data_q;
    logic          parity_err_q;
    logic          frame_err_q;

    logic [1:0]    idx_q;
    logic [7:0]    pb_q [4];
    logic [7:0]    pkt_w [4];
    logic [PW-1:0] ptmr_q;
    logic          pkt_valid_q;
    logic          sync_err_q;
    logic [2:0]    btn_q;
    logic [8:0]    dx_q, dy_q;
    logic          x_ovf_q, y_ovf_q;
    logic [3:0]    dz_q;
    logic          unused_bits;

    assign s_clk = clk_sync_q[SYNC_STAGES-1];
    assign s_dat = dat_sync_q[SYNC_STAGES-1];

    // Shift both asynchronous pins through the synchroniser chains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // Filtered clock follows the pin only after a run of equal samples.
    always_comb begin
        fclk_d = fclk_q;
        fcnt_d = '0;
        if (s_clk != fclk_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                fclk_d = s_clk;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    // Filter state, falling-edge strobe and the data sample that goes with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fclk_q <= 1'b1;
            fcnt_q <= '0;
            fall_q <= 1'b0;
            fdat_q <= 1'b1;
        end else begin
            fclk_q <= fclk_d;
            fcnt_q <= fcnt_d;
            fall_q <= fclk_q & ~fclk_d;
            fdat_q <= s_dat;
        end
    end

    // Frame FSM next state: deserialise, check parity/stop, bit timeout.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bcnt_d  = bcnt_q;
        par_d   = par_q;
        btmr_d  = '0;
        bv_d    = 1'b0;
        pe_d    = 1'b0;
        fe_d    = 1'b0;
        bd_d    = byte_data_q;
        if (state_q != IDLE && !fall_q) begin
            btmr_d = btmr_q + BW'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (fall_q && !fdat_q) begin
                    sh_d    = '0;
                    bcnt_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (fall_q) begin
                    sh_d   = {fdat_q, sh_q[7:1]};
                    bcnt_d = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall_q) begin
                    par_d   = fdat_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall_q) begin
                    state_d = IDLE;
                    if (!fdat_q) begin
                        fe_d = 1'b1;
                    end else if (^{par_q, sh_q}) begin
                        bv_d = 1'b1;
                        bd_d = sh_q;
                    end else begin
                        pe_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!fall_q && state_q != IDLE && btmr_q == BW'(BIT_TIMEOUT)) begin
            fe_d    = 1'b1;
            btmr_d  = '0;
            state_d = IDLE;
        end
    end

    // Frame FSM registers and registered byte/error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sh_q         <= '0;
            bcnt_q       <= '0;
            par_q        <= 1'b0;
            btmr_q       <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            bcnt_q       <= bcnt_d;
            par_q        <= par_d;
            btmr_q       <= btmr_d;
            byte_valid_q <= bv_d;
            byte_data_q  <= bd_d;
            parity_err_q <= pe_d;
            frame_err_q  <= fe_d;
        end
    end

    // Packet view with the incoming byte dropped into its slot.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pkt_w[i] = (idx_q == 2'(i)) ? byte_data_q : pb_q[i];
        end
    end

    assign unused_bits = ^{pkt_w[0][3], pkt_w[3][7:4]};

    // Packet assembler: byte0 sync, slot fill, decode, error and timeout drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            ptmr_q      <= '0;
            pkt_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            btn_q       <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            x_ovf_q     <= 1'b0;
            y_ovf_q     <= 1'b0;
            dz_q        <= '0;
            for (int i = 0; i < 4; i++) begin
                pb_q[i] <= '0;
            end
        end else begin
            pkt_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            if (parity_err_q || frame_err_q) begin
                idx_q  <= '0;
                ptmr_q <= '0;
            end else if (byte_valid_q) begin
                ptmr_q <= '0;
                if (idx_q == 2'd0 && !byte_data_q[3]) begin
                    sync_err_q <= 1'b1;
                end else begin
                    pb_q[idx_q] <= byte_data_q;
                    if (idx_q == 2'(PKT_BYTES - 1)) begin
                        idx_q       <= '0;
                        pkt_valid_q <= 1'b1;
                        btn_q       <= pkt_w[0][2:0];
                        dx_q        <= {pkt_w[0][4], pkt_w[1]};
                        dy_q        <= {pkt_w[0][5], pkt_w[2]};
                        x_ovf_q     <= pkt_w[0][6];
                        y_ovf_q     <= pkt_w[0][7];
                        dz_q        <= (PKT_BYTES == 4) ? pkt_w[3][3:0] : 4'h0;
                    end else begin
                        idx_q <= idx_q + 2'd1;
                    end
                end
            end else if (idx_q != 2'd0) begin
                if (ptmr_q == PW'(PKT_TIMEOUT)) begin
                    idx_q  <= '0;
                    ptmr_q <= '0;
                end else begin
                    ptmr_q <= ptmr_q + PW'(1);
                end
            end else begin
                ptmr_q <= '0;
            end
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign pkt_valid  = pkt_valid_q;
    assign sync_err   = sync_err_q;
    assign btn        = btn_q;
    assign dx         = dx_q;
    assign dy         = dy_q;
    assign x_ovf      = x_ovf_q;
    assign y_ovf      = y_ovf_q;
    assign dz         = dz_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Bench for ps2_mouse_rx: 3-byte and 4-byte instances on shared pins,
// checked against a packet-level reference model.
module tb_ps2_mouse_rx;

    localparam int SS = 2;
    localparam int FL = 4;
    localparam int BT = 400;
    localparam int PT = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    logic       bv [2];
    logic [7:0] bd [2];
    logic       pv [2];
    logic [2:0] bt [2];
    logic [8:0] dxo [2];
    logic [8:0] dyo [2];
    logic       xo [2];
    logic       yo [2];
    logic [3:0] dzo [2];
    logic       pe [2];
    logic       fe [2];
    logic       se [2];

    int checks = 0;
    int errors = 0;

    int n_bv [2], n_pv [2], n_pe [2], n_fe [2], n_se [2];
    int e_bv [2], e_pv [2], e_pe [2], e_fe [2], e_se [2];
    logic [7:0] e_bd [2];
    logic [2:0] e_btn [2];
    logic [8:0] e_dx [2], e_dy [2];
    logic       e_xo [2], e_yo [2];
    logic [3:0] e_dz [2];
    int         m_idx [2];
    logic [7:0] m_pkt [2][4];

    ps2_mouse_rx #(.PKT_BYTES(3), .SYNC_STAGES(SS), .FILTER_LEN(FL),
                   .BIT_TIMEOUT(BT), .PKT_TIMEOUT(PT)) u3 (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .byte_valid(bv[0]), .byte_data(bd[0]), .pkt_valid(pv[0]),
        .btn(bt[0]), .dx(dxo[0]), .dy(dyo[0]), .x_ovf(xo[0]), .y_ovf(yo[0]),
        .dz(dzo[0]), .parity_err(pe[0]), .frame_err(fe[0]), .sync_err(se[0])
    );

    ps2_mouse_rx #(.PKT_BYTES(4), .SYNC_STAGES(SS), .FILTER_LEN(FL),
                   .BIT_TIMEOUT(BT), .PKT_TIMEOUT(PT)) u4 (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .byte_valid(bv[1]), .byte_data(bd[1]), .pkt_valid(pv[1]),
        .btn(bt[1]), .dx(dxo[1]), .dy(dyo[1]), .x_ovf(xo[1]), .y_ovf(yo[1]),
        .dz(dzo[1]), .parity_err(pe[1]), .frame_err(fe[1]), .sync_err(se[1])
    );

    always #5 clk = ~clk;

    // Count output pulses away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (bv[k] === 1'b1) n_bv[k]++;
            if (pv[k] === 1'b1) n_pv[k]++;
            if (pe[k] === 1'b1) n_pe[k]++;
            if (fe[k] === 1'b1) n_fe[k]++;
            if (se[k] === 1'b1) n_se[k]++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_idx[k] = 0;
            e_bd[k]  = '0;
            e_btn[k] = '0;
            e_dx[k]  = '0;
            e_dy[k]  = '0;
            e_xo[k]  = 1'b0;
            e_yo[k]  = 1'b0;
            e_dz[k]  = '0;
        end
    endtask

    // Reference behaviour of one received frame for both packet sizes.
    task automatic model_frame(input logic [7:0] b, input bit pbad,
                               input bit sbad);
        for (int k = 0; k < 2; k++) begin
            int n;
            n = (k == 0) ? 3 : 4;
            if (sbad) begin
                e_fe[k]++;
                m_idx[k] = 0;
            end else if (pbad) begin
                e_pe[k]++;
                m_idx[k] = 0;
            end else begin
                e_bv[k]++;
                e_bd[k] = b;
                if (m_idx[k] == 0 && b[3] == 1'b0) begin
                    e_se[k]++;
                end else begin
                    m_pkt[k][m_idx[k]] = b;
                    m_idx[k]++;
                    if (m_idx[k] == n) begin
                        e_pv[k]++;
                        e_btn[k] = m_pkt[k][0][2:0];
                        e_dx[k]  = {m_pkt[k][0][4], m_pkt[k][1]};
                        e_dy[k]  = {m_pkt[k][0][5], m_pkt[k][2]};
                        e_xo[k]  = m_pkt[k][0][6];
                        e_yo[k]  = m_pkt[k][0][7];
                        e_dz[k]  = (n == 4) ? m_pkt[k][3][3:0] : 4'h0;
                        m_idx[k] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            string t;
            t = $sformatf("%s/i%0d/", tag, k);
            chk({t, "nbyte"}, n_bv[k], e_bv[k]);
            chk({t, "npkt"}, n_pv[k], e_pv[k]);
            chk({t, "nperr"}, n_pe[k], e_pe[k]);
            chk({t, "nferr"}, n_fe[k], e_fe[k]);
            chk({t, "nserr"}, n_se[k], e_se[k]);
            chk({t, "byte"}, 32'(bd[k]), 32'(e_bd[k]));
            chk({t, "btn"}, 32'(bt[k]), 32'(e_btn[k]));
            chk({t, "dx"}, 32'(dxo[k]), 32'(e_dx[k]));
            chk({t, "dy"}, 32'(dyo[k]), 32'(e_dy[k]));
            chk({t, "xovf"}, 32'(xo[k]), 32'(e_xo[k]));
            chk({t, "yovf"}, 32'(yo[k]), 32'(e_yo[k]));
            chk({t, "dz"}, 32'(dzo[k]), 32'(e_dz[k]));
        end
    endtask

    task automatic check_quiet(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s/i%0d/pulses", tag, k),
                32'({bv[k], pv[k], pe[k], fe[k], se[k]}), 32'h0);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        cyc(10);
        ps2_clk = 1'b0;
        cyc(20);
        ps2_clk = 1'b1;
        cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit pbad,
                              input bit sbad);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ pbad);
        send_bit(~sbad);
        ps2_data = 1'b1;
        cyc(40);
        model_frame(b, pbad, sbad);
        check_all($sformatf("frame%02h", b));
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    task automatic std_pkt();
        send_good(8'h29);
        send_good(8'h05);
        send_good(8'hFB);
    endtask

    task automatic idle_pkt();
        cyc(PT + 100);
        m_idx[0] = 0;
        m_idx[1] = 0;
        check_all("idle");
    endtask

    initial begin
        logic [7:0] rb;
        bit         rp;
        bit         rs;
        for (int k = 0; k < 2; k++) begin
            n_bv[k] = 0; n_pv[k] = 0; n_pe[k] = 0; n_fe[k] = 0; n_se[k] = 0;
            e_bv[k] = 0; e_pv[k] = 0; e_pe[k] = 0; e_fe[k] = 0; e_se[k] = 0;
        end
        model_reset();
        cyc(5);
        check_all("reset");
        check_quiet("reset");
        rst_n = 1'b1;
        cyc(20);
        check_all("post_reset");

        std_pkt();
        idle_pkt();

        send_good(8'h29);
        send_frame(8'h05, 1'b1, 1'b0);
        std_pkt();
        idle_pkt();

        send_good(8'h05);
        std_pkt();
        idle_pkt();

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        cyc(BT + 200);
        for (int k = 0; k < 2; k++) begin
            e_fe[k]++;
            m_idx[k] = 0;
        end
        check_all("bit_timeout");
        std_pkt();
        idle_pkt();

        send_good(8'h29);
        send_good(8'h05);
        idle_pkt();
        std_pkt();
        idle_pkt();

        send_good(8'h08);
        send_good(8'h00);
        send_good(8'h00);
        send_good(8'h0F);
        idle_pkt();

        ps2_data = 1'b0;
        cyc(5);
        ps2_clk = 1'b0;
        cyc(2);
        ps2_clk = 1'b1;
        cyc(20);
        ps2_data = 1'b1;
        cyc(20);
        check_all("glitch");
        std_pkt();
        idle_pkt();

        send_frame(8'h29, 1'b0, 1'b1);
        send_frame(8'h29, 1'b1, 1'b1);

        for (int n = 0; n < 36; n++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 1) == 1) rb[3] = 1'b1;
            rp = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 15) == 0);
            send_frame(rb, rp, rs);
        end

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n = 1'b0;
        ps2_data = 1'b1;
        cyc(3);
        model_reset();
        check_all("mid_reset");
        check_quiet("mid_reset");
        rst_n = 1'b1;
        cyc(20);
        std_pkt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
